// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_e;

    // Double-dabble digit correction: digits >= 5 get +3 before each shift.
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    // Display path: one byte shown on three seven-segment digits.
    localparam int DEF_IN_W   = 8;
    localparam int DEF_DIGITS = 3;

endpackage

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// Combinational "if >= 5 add 3" cell for one BCD digit.
// The largest legal input is 9, so the 4-bit sum tops out at 12 and never carries.
module bcd_digit_adj
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= BCD_ADJ_THRESH) ? (digit_i + BCD_ADJ_ADD) : digit_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Feeds the 3-digit seven-segment decoder; out_bcd holds the last result.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | waiting for in_valid; in_ready high
//   CONVERT | IN_W adjust+shift steps, one per clock
//   DONE    | single cycle, out_valid high, back to IDLE
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int IN_W   = DEF_IN_W,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       in_bin,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_valid,
    output logic                  busy
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);

    // The full input range must fit in the available digits.
    if (((2 ** IN_W) - 1) >= (10 ** DIGITS)) begin : g_width_check
        $error("bin_to_bcd_seq: IN_W too wide for DIGITS");
    end

    state_e             state_q, state_d;
    logic [IN_W-1:0]    sh_q, sh_d;
    logic [BCD_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   out_bcd_q, out_bcd_d;
    logic               out_valid_q;

    logic [BCD_W-1:0]   acc_adj;
    logic [BCD_W-1:0]   acc_sh;
    logic [IN_W-1:0]    sh_sh;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (acc_q[4*g +: 4]),
            .digit_o (acc_adj[4*g +: 4])
        );
    end

    assign {acc_sh, sh_sh} = {acc_adj, sh_q} << 1;

    // Next-state, datapath and result-capture decisions.
    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        out_bcd_d = out_bcd_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sh_d    = in_bin;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                acc_d = acc_sh;
                sh_d  = sh_sh;
                if (cnt_q == CNT_LAST) begin
                    out_bcd_d = acc_sh;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_bcd_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_bcd_q   <= out_bcd_d;
            out_valid_q <= (state_d == DONE);
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == CONVERT) || (state_q == DONE);
    assign out_bcd   = out_bcd_q;
    assign out_valid = out_valid_q;

endmodule
